// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch/data) arbiter for a single 16-bit memory port with fixed-latency access FSM.
// Optional fetch/data alternation under contention is enabled by defining MEM_ARB_FAIR_EN.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic        busy
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [3:0] WC     = 4'(WAIT_CYCLES);
  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        own_d, we_r, byte_r;
  logic [15:0] addr_r, wdata_r, g_addr;
  logic        pick_d, last, acc;
`ifdef MEM_ARB_FAIR_EN
  logic fair;
  assign pick_d = d_req && !(if_req && fair);
`else
  assign pick_d = d_req;
`endif
  assign g_addr = pick_d ? d_addr : if_addr;
  assign last   = cnt == WC;
  assign acc    = state == ACCESS;
  assign mem_addr  = {addr_r[15:1], 1'b0};
  assign mem_wdata = wdata_r;
  // Lane enables are derived from the latched request so the port never sees live requester inputs
  assign mem_be  = !acc ? 2'b00 : !byte_r ? 2'b11 : addr_r[0] ? 2'b10 : 2'b01;
  assign mem_re  = acc && !we_r;
  assign mem_we  = acc && we_r;
  assign if_done = state == DONE && !own_d;
  assign d_done  = state == DONE && own_d;
  assign busy    = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      own_d    <= 1'b0;
      we_r     <= 1'b0;
      byte_r   <= 1'b0;
      addr_r   <= 16'h0000;
      wdata_r  <= 16'h0000;
      if_rdata <= 16'h0000;
      d_rdata  <= 16'h0000;
`ifdef MEM_ARB_FAIR_EN
      fair     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (d_req || if_req) begin
          state  <= ACCESS;
          cnt    <= 4'd0;
          own_d  <= pick_d;
          we_r   <= pick_d && d_we;
          byte_r <= pick_d && d_byte;
          addr_r <= g_addr;
          if (pick_d) wdata_r <= d_byte ? {2{d_wdata[7:0]}} : d_wdata;
`ifdef MEM_ARB_FAIR_EN
          fair   <= pick_d;
`endif
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last) begin
            state <= DONE;
            if (own_d) d_rdata <= !byte_r ? mem_rdata : {8'h00, addr_r[0] ? mem_rdata[15:8] : mem_rdata[7:0]};
            else if_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
